// File: rtl/eth_pkg.sv
// eth_pkg: constants and types shared by the RMII receive deframer.
//   - RMII line symbols: preamble dibit and SFD tail dibit
//   - Ethernet header length
//   - CRC-32 polynomial (reflected form) and init value, with a
//     byte-wide update helper
//   - Err_Code encodings reported alongside Frame_Err
//   - Receive FSM state encoding
package eth_pkg;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_TAIL_DIBIT = 2'b11;

    localparam int HDR_LEN = 14;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CRC   = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_FRAME    = 2'd2,
        ST_DROP     = 2'd3
    } state_e;

    // One byte of reflected CRC-32, LSB of the data byte first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: IEEE 802.3 CRC-32, one byte per clock.
// Ports:
//   Clk, Rst  clock, asynchronous active-high reset
//   En_i      fold Data_i into the running CRC this cycle
//   Clr_i     restart the CRC from the init value (wins over En_i)
//   Data_i    byte to fold in
//   Crc_o     running CRC with the final XOR applied
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En_i,
    input  logic        Clr_i,
    input  logic [7:0]  Data_i,
    output logic [31:0] Crc_o
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (Clr_i) begin
            crc_d = CRC_INIT;
        end else if (En_i) begin
            crc_d = crc32_step(crc_q, Data_i);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign Crc_o = crc_q ^ CRC_INIT;

endmodule

// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer: RMII receive deframer. Strips preamble/SFD, captures the
// 14-byte header, streams payload bytes and checks FCS/alignment/length.
// Ports:
//   Clk, Rst              clock, asynchronous active-high reset
//   Rx_Data, Rx_Dv        RMII dibit (LSB-first within a byte) and qualifier
//   M_Data/M_Valid/M_Last payload stream
//   Dest_Addr, Src_Addr, Len_Type, Hdr_Valid   captured header + pulse
//   Frame_Good, Frame_Err, Err_Code            end-of-frame status
//   State_Dbg             current FSM state, for observation only
// Stream handshake: M_Valid is a one-cycle pulse per byte with no ready
// signal; the consumer must take M_Data on every cycle M_Valid is high.
// M_Last rides with the final byte, in the same cycle as the status pulse.
module eth_rx_deframer
    import eth_pkg::*;
#(
    parameter int pMIN_LEN = 60,
    parameter int pMAX_LEN = 1514
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Rx_Data,
    input  logic        Rx_Dv,
    output logic [7:0]  M_Data,
    output logic        M_Valid,
    output logic        M_Last,
    output logic [47:0] Dest_Addr,
    output logic [47:0] Src_Addr,
    output logic [15:0] Len_Type,
    output logic        Hdr_Valid,
    output logic        Frame_Good,
    output logic        Frame_Err,
    output logic [1:0]  Err_Code,
    output state_e      State_Dbg
);

    localparam logic [10:0] MIN_CNT = 11'(pMIN_LEN);
    localparam logic [10:0] MAX_CNT = 11'(pMAX_LEN);
    localparam logic [10:0] HDR_CNT = 11'(HDR_LEN);

    state_e      state_q, state_d;
    logic        armed_q, armed_d;           // Rx_Dv seen low since reset
    logic [7:0]  shift_q, shift_d;           // byte under assembly
    logic [1:0]  dibit_cnt_q, dibit_cnt_d;
    logic [31:0] win_q, win_d;               // [31:24] oldest, [7:0] newest
    logic [2:0]  win_cnt_q, win_cnt_d;
    logic [10:0] exit_cnt_q, exit_cnt_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [47:0] dest_q, dest_d, src_q, src_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic        hdr_valid_q, hdr_valid_d, good_q, good_d, err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        crc_en, crc_clr;
    logic [31:0] crc_val, fcs_rx;
    logic [7:0]  byte_in, exit_byte;

    eth_crc32_d8 u_crc (
        .Clk    (Clk),
        .Rst    (Rst),
        .En_i   (crc_en),
        .Clr_i  (crc_clr),
        .Data_i (exit_byte),
        .Crc_o  (crc_val)
    );

    assign byte_in   = {Rx_Data, shift_q[7:2]};
    assign exit_byte = win_q[31:24];
    // FCS arrives least-significant byte first.
    assign fcs_rx    = {win_q[7:0], win_q[15:8], win_q[23:16], win_q[31:24]};

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | ~Rx_Dv;
        shift_d     = shift_q;
        dibit_cnt_d = dibit_cnt_q;
        win_d       = win_q;
        win_cnt_d   = win_cnt_q;
        exit_cnt_d  = exit_cnt_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        dest_d      = dest_q;
        src_d       = src_q;
        len_d       = len_q;
        m_data_d    = m_data_q;
        m_valid_d   = 1'b0;
        m_last_d    = 1'b0;
        hdr_valid_d = 1'b0;
        good_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = ERR_NONE;
        crc_en      = 1'b0;
        crc_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Rx_Dv) begin
                    // After a reset mid-frame, ignore the tail of that frame.
                    if (!armed_q)                        state_d = ST_DROP;
                    else if (Rx_Data == PREAMBLE_DIBIT) state_d = ST_PREAMBLE;
                    else if (Rx_Data != 2'b00)          state_d = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!Rx_Dv) begin
                    state_d = ST_IDLE;
                end else if (Rx_Data == SFD_TAIL_DIBIT) begin
                    state_d     = ST_FRAME;
                    crc_clr     = 1'b1;
                    dibit_cnt_d = 2'd0;
                    win_cnt_d   = 3'd0;
                    exit_cnt_d  = 11'd0;
                    pend_vld_d  = 1'b0;
                end else if (Rx_Data != PREAMBLE_DIBIT) begin
                    state_d = ST_DROP;
                end
            end
            ST_FRAME: begin
                if (!Rx_Dv) begin
                    state_d    = ST_IDLE;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        m_data_d  = pend_q;
                    end
                    if (exit_cnt_q < MIN_CNT) begin
                        err_d = 1'b1;  err_code_d = ERR_LEN;
                    end else if (dibit_cnt_q != 2'd0) begin
                        err_d = 1'b1;  err_code_d = ERR_ALIGN;
                    end else if (crc_val != fcs_rx) begin
                        err_d = 1'b1;  err_code_d = ERR_CRC;
                    end else begin
                        good_d = 1'b1;
                    end
                end else begin
                    shift_d     = byte_in;
                    dibit_cnt_d = dibit_cnt_q + 2'd1;
                    if (dibit_cnt_q == 2'd3) begin
                        win_d = {win_q[23:0], byte_in};
                        if (win_cnt_q != 3'd4) begin
                            win_cnt_d = win_cnt_q + 3'd1;
                        end else if (exit_cnt_q == MAX_CNT) begin
                            // Oversize: close out now and discard the rest.
                            state_d    = ST_DROP;
                            pend_vld_d = 1'b0;
                            m_valid_d  = pend_vld_q;
                            m_last_d   = pend_vld_q;
                            m_data_d   = pend_q;
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                        end else begin
                            crc_en     = 1'b1;
                            exit_cnt_d = exit_cnt_q + 11'd1;
                            if (exit_cnt_q < 11'd6) begin
                                dest_d = {dest_q[39:0], exit_byte};
                            end else if (exit_cnt_q < 11'd12) begin
                                src_d = {src_q[39:0], exit_byte};
                            end else if (exit_cnt_q < HDR_CNT) begin
                                len_d       = {len_q[7:0], exit_byte};
                                hdr_valid_d = (exit_cnt_q == HDR_CNT - 11'd1);
                            end else begin
                                // Hold one byte back so the last one can carry M_Last.
                                if (pend_vld_q) begin
                                    m_valid_d = 1'b1;
                                    m_data_d  = pend_q;
                                end
                                pend_d     = exit_byte;
                                pend_vld_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!Rx_Dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            shift_q     <= '0;
            dibit_cnt_q <= '0;
            win_q       <= '0;
            win_cnt_q   <= '0;
            exit_cnt_q  <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            dest_q      <= '0;
            src_q       <= '0;
            len_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            hdr_valid_q <= 1'b0;
            good_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            shift_q     <= shift_d;
            dibit_cnt_q <= dibit_cnt_d;
            win_q       <= win_d;
            win_cnt_q   <= win_cnt_d;
            exit_cnt_q  <= exit_cnt_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            len_q       <= len_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            hdr_valid_q <= hdr_valid_d;
            good_q      <= good_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign M_Data     = m_data_q;
    assign M_Valid    = m_valid_q;
    assign M_Last     = m_last_q;
    assign Dest_Addr  = dest_q;
    assign Src_Addr   = src_q;
    assign Len_Type   = len_q;
    assign Hdr_Valid  = hdr_valid_q;
    assign Frame_Good = good_q;
    assign Frame_Err  = err_q;
    assign Err_Code   = err_code_q;
    assign State_Dbg  = state_q;

endmodule
